// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard for in-order issue / out-of-order writeback.
// Register 0 is hardwired to zero; optional same-cycle writeback forwarding on both read ports.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_act;
  logic             issue_act;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  assign wb_act    = wb_en && (wb_rd != '0);
  assign issue_act = issue_en && (issue_rd != '0);

  // Issue is applied after writeback so a same-register issue wins the busy bit.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_act)    busy_nxt[wb_rd]    = 1'b0;
      if (issue_act) busy_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wb_act) regs[wb_rd] <= wb_data;
      busy       <= busy_nxt;
      busy_count <= popcount(busy_nxt);
    end
  end

  always_comb begin
    read_data1 = (rs1 == '0) ? '0 : regs[rs1];
    read_data2 = (rs2 == '0) ? '0 : regs[rs2];
    busy1      = (rs1 == '0) ? 1'b0 : busy[rs1];
    busy2      = (rs2 == '0) ? 1'b0 : busy[rs2];
    if (BYPASS != 0) begin
      if (wb_act && (wb_rd == rs1)) begin
        read_data1 = wb_data;
        busy1      = issue_en && (issue_rd == rs1);
      end
      if (wb_act && (wb_rd == rs2)) begin
        read_data2 = wb_data;
        busy2      = issue_en && (issue_rd == rs2);
      end
    end
  end

endmodule
